parity_frame_tx: RTL and testbench

Serial transmitter controller that sequences the board's 4-bit parity datapath. On a start-button press it latches `sw[3:0]`, computes the parity bit, and shifts out a UART-style frame on `txd`: start bit, 4 data bits LSB first, parity bit, stop bit. It is the first block that adds timing and sequencing to the switch/LED parity logic, and it drives the board LEDs with status.

---
 rtl/parity_frame_tx_pkg.sv | 21 ++
 rtl/parity_frame_tx_btn_sync_edge.sv | 28 ++
 rtl/parity_frame_tx.sv | 122 ++++++++++++
 tb/tb_parity_frame_tx.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/parity_frame_tx_pkg.sv
// Shared definitions for the parity frame transmitter: state encoding,
// frame geometry and the odd-parity helper.
package parity_frame_tx_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } state_t;

   localparam int FRAME_BITS = 7;
   localparam int DATA_BITS  = 4;

   // Odd parity: 1 when the nibble has an even number of ones.
   function automatic logic frame_parity(input logic [DATA_BITS-1:0] d);
      return ~^d;
   endfunction

endpackage

// File: rtl/parity_frame_tx_btn_sync_edge.sv
// Button synchronizer with rising-edge detect; emits a registered one-cycle
// pulse per rising edge of the asynchronous button level.
module btn_sync_edge (
   input  logic clk,
   input  logic rst,
   input  logic btn,
   output logic pulse
);

   logic sync1;
   logic sync2;
   logic edge_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1  <= 1'b0;
         sync2  <= 1'b0;
         edge_q <= 1'b0;
         pulse  <= 1'b0;
      end else begin
         sync1  <= btn;
         sync2  <= sync1;
         edge_q <= sync2;
         pulse  <= sync2 & ~edge_q;
      end
   end

endmodule

// File: rtl/parity_frame_tx.sv
// Serial frame transmitter: start bit, 4 data bits LSB first, odd parity,
// stop bit, launched by a button edge, with status on the LEDs.
module parity_frame_tx
   import parity_frame_tx_pkg::*;
#(
   parameter int BIT_CYCLES = 5208
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] sw,
   input  logic       btn,
   output logic       txd,
   output logic [7:0] ld
);

   localparam int TW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
   localparam logic [TW-1:0] BIT_LAST = TW'(BIT_CYCLES - 1);
   localparam logic [1:0]    IDX_LAST = 2'(DATA_BITS - 1);

   state_t                 state;
   state_t                 state_next;
   logic [TW-1:0]          timer;
   logic [TW-1:0]          timer_next;
   logic [1:0]             idx;
   logic [1:0]             idx_next;
   logic [DATA_BITS-1:0]   data;
   logic [DATA_BITS-1:0]   data_next;
   logic                   par;
   logic                   par_next;
   logic                   done;
   logic                   done_next;
   logic                   txd_next;
   logic                   start;
   logic                   bit_end;
   logic                   busy;

   btn_sync_edge u_btn (
      .clk   (clk),
      .rst   (rst),
      .btn   (btn),
      .pulse (start)
   );

   assign bit_end = (timer == BIT_LAST);
   assign busy    = (state != IDLE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         timer <= '0;
         idx   <= '0;
         data  <= '0;
         par   <= 1'b0;
         done  <= 1'b0;
         txd   <= 1'b1;
      end else begin
         state <= state_next;
         timer <= timer_next;
         idx   <= idx_next;
         data  <= data_next;
         par   <= par_next;
         done  <= done_next;
         txd   <= txd_next;
      end
   end

   // txd is decoded from the next state so the line is registered yet
   // changes on the same edge as the state it belongs to.
   always_comb begin
      state_next = state;
      timer_next = timer;
      idx_next   = idx;
      data_next  = data;
      par_next   = par;
      done_next  = done;

      if (state == IDLE) begin
         if (start) begin
            data_next  = sw;
            par_next   = frame_parity(sw);
            done_next  = 1'b0;
            timer_next = '0;
            idx_next   = '0;
            state_next = START;
         end
      end else begin
         timer_next = bit_end ? '0 : timer + TW'(1);
         if (bit_end) begin
            case (state)
               START: begin
                  state_next = DATA;
                  idx_next   = '0;
               end
               DATA: begin
                  if (idx == IDX_LAST) begin
                     state_next = PARITY;
                     idx_next   = '0;
                  end else begin
                     idx_next = idx + 2'd1;
                  end
               end
               PARITY: state_next = STOP;
               STOP: begin
                  state_next = IDLE;
                  done_next  = 1'b1;
               end
               default: state_next = IDLE;
            endcase
         end
      end

      case (state_next)
         START:   txd_next = 1'b0;
         DATA:    txd_next = data_next[idx_next];
         PARITY:  txd_next = par_next;
         default: txd_next = 1'b1;
      endcase
   end

   assign ld = {txd, done, busy, par, data};

endmodule

// File: tb/tb_parity_frame_tx.sv
// Directed bench for parity_frame_tx with BIT_CYCLES=4: frame contents,
// latency, busy/done status, ignored presses, latching and mid-frame reset.
module tb_parity_frame_tx;
   import parity_frame_tx_pkg::*;

   localparam int BC           = 4;
   localparam int FRAME_CYCLES = FRAME_BITS * BC;

   logic       clk = 1'b0;
   logic       rst;
   logic       btn;
   logic [3:0] sw;
   logic       txd;
   logic [7:0] ld;

   int vectors     = 0;
   int miscompares = 0;

   parity_frame_tx #(.BIT_CYCLES(BC)) dut (
      .clk (clk),
      .rst (rst),
      .sw  (sw),
      .btn (btn),
      .txd (txd),
      .ld  (ld)
   );

   always #5 clk = ~clk;

   task automatic check_output(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
      vectors++;
      assert (observed === expected) else begin
         miscompares++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   task automatic apply_stimulus(input logic [3:0] s);
      sw  = s;
      btn = 1'b1;
   endtask

   task automatic wait_low(output int cycles);
      cycles = 0;
      while (txd !== 1'b0 && cycles < 60) begin
         @(negedge clk);
         cycles++;
      end
   endtask

   // Samples one frame starting at the negedge where txd first reads 0.
   // action 1 drops btn at act_cycle and raises it again two cycles later;
   // action 2 switches sw to 4'hC at act_cycle.
   task automatic shift_frame(input int action, input int act_cycle,
                              output logic [6:0] bits, output int busy_cycles,
                              output int unstable, output logic [7:0] first_ld);
      bits        = '0;
      busy_cycles = 0;
      unstable    = 0;
      first_ld    = ld;
      for (int c = 0; c < FRAME_CYCLES; c++) begin
         if (action == 1 && c == act_cycle)     btn = 1'b0;
         if (action == 1 && c == act_cycle + 2) btn = 1'b1;
         if (action == 2 && c == act_cycle)     sw  = 4'hC;
         if (c % BC == 0) bits[c / BC] = txd;
         else if (txd !== bits[c / BC]) unstable++;
         if (ld[5] === 1'b1) busy_cycles++;
         @(negedge clk);
      end
   endtask

   task automatic hold_idle(input int n, output int lows);
      lows = 0;
      for (int c = 0; c < n; c++) begin
         if (txd !== 1'b1) lows++;
         @(negedge clk);
      end
   endtask

   initial begin
      logic [6:0] bits;
      logic [7:0] first_ld;
      int         busy;
      int         unst;
      int         lat;
      int         lows;

      rst = 1'b1;
      btn = 1'b0;
      sw  = 4'h0;
      #1;
      check_output("reset_ld", 32'(ld), 32'h80);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      check_output("idle_ld", 32'(ld), 32'h80);

      $display("[TB] basic frame sw=0101 with a second press during DATA");
      apply_stimulus(4'b0101);
      wait_low(lat);
      check_output("basic_latency", 32'(lat), 32'd4);
      shift_frame(1, 8, bits, busy, unst, first_ld);
      check_output("basic_bits", 32'(bits), 32'b1101010);
      check_output("basic_stable", 32'(unst), 32'd0);
      check_output("basic_busy_cycles", 32'(busy), 32'(FRAME_CYCLES));
      check_output("basic_first_ld", 32'(first_ld), 32'h35);
      check_output("basic_done_ld", 32'(ld), 32'hD5);
      hold_idle(20, lows);
      check_output("busy_press_ignored", 32'(lows), 32'd0);
      check_output("held_ld", 32'(ld), 32'hD5);
      btn = 1'b0;
      repeat (6) @(negedge clk);

      $display("[TB] odd data sw=0111 with back-to-back press");
      apply_stimulus(4'b0111);
      wait_low(lat);
      check_output("odd_latency", 32'(lat), 32'd4);
      shift_frame(1, 23, bits, busy, unst, first_ld);
      check_output("odd_bits", 32'(bits), 32'b1001110);
      check_output("odd_stable", 32'(unst), 32'd0);
      check_output("odd_first_ld", 32'(first_ld), 32'h27);
      check_output("odd_done_ld", 32'(ld), 32'hC7);
      check_output("odd_line_ones", 32'($countones(bits[5:1])), 32'd3);
      wait_low(lat);
      check_output("b2b_gap", 32'(lat), 32'd1);
      shift_frame(0, 0, bits, busy, unst, first_ld);
      check_output("b2b_bits", 32'(bits), 32'b1001110);
      check_output("b2b_busy_cycles", 32'(busy), 32'(FRAME_CYCLES));
      check_output("b2b_first_ld", 32'(first_ld), 32'h27);
      check_output("b2b_done_ld", 32'(ld), 32'hC7);
      btn = 1'b0;
      repeat (6) @(negedge clk);

      $display("[TB] latched data sw=3 changed to C mid-frame");
      apply_stimulus(4'h3);
      wait_low(lat);
      check_output("latch_latency", 32'(lat), 32'd4);
      shift_frame(2, 6, bits, busy, unst, first_ld);
      check_output("latch_bits", 32'(bits), 32'b1100110);
      check_output("latch_stable", 32'(unst), 32'd0);
      check_output("latch_first_ld", 32'(first_ld), 32'h33);
      check_output("latch_done_ld", 32'(ld), 32'hD3);
      btn = 1'b0;
      repeat (6) @(negedge clk);

      $display("[TB] reset during PARITY with button held");
      apply_stimulus(4'hA);
      wait_low(lat);
      check_output("rst_frame_latency", 32'(lat), 32'd4);
      repeat (21) @(negedge clk);
      rst = 1'b1;
      #1;
      check_output("reset_mid_ld", 32'(ld), 32'h80);
      @(negedge clk);
      sw  = 4'h6;
      rst = 1'b0;
      wait_low(lat);
      check_output("rst_release_latency", 32'(lat), 32'd4);
      shift_frame(0, 0, bits, busy, unst, first_ld);
      check_output("rst_new_bits", 32'(bits), 32'b1101100);
      check_output("rst_new_busy_cycles", 32'(busy), 32'(FRAME_CYCLES));
      check_output("rst_new_done_ld", 32'(ld), 32'hD6);
      hold_idle(20, lows);
      check_output("rst_single_frame", 32'(lows), 32'd0);
      btn = 1'b0;
      repeat (2) @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
